parking_gate_ctrl: RTL
======================

# parking_gate_ctrl

Entry-barrier controller for the parking system. It is the producing end of the space counter's entry interface. It admits a car only when the counter reports free space, then sequences the barrier motor. It confirms the car has physically passed and only then issues a single-cycle `entry_pulse` to the space counter. Aborted or timed-out admissions never decrement the count.

## Interface
- `MOVE_CYCLES`, default 4: barrier travel time in clk cycles, up or down; must be ≥1.
- `OPEN_CYCLES`, default 16: maximum cycles the barrier stays open waiting for the car; must be ≥1.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `request`  in  1  car waiting at gate (debounced, synchronous level).
- `space_avail`  in  1  counter has ≥1 free space (counter's green output).
- `pass_sensor`  in  1  beam under barrier broken (debounced, synchronous level).
- `motor_up`  out  1  drive barrier up.
- `motor_down`  out  1  drive barrier down.
- `barrier_open`  out  1  barrier fully up.
- `deny`  out  1  request present, armed, but no space.
- `entry_pulse`  out  1  one-cycle pulse: car admitted; wired to counter entry.
- `timeout`  out  1  one-cycle pulse: open window expired without a pass.

## Operation
- States: IDLE, RAISING, OPEN, PASSING, LOWERING (one-hot or binary, implementer's choice).
- Internal `armed` flag:
  - Set whenever `request` is sampled low.
  - Cleared on entering RAISING.
  - Reset value 1.
  - A car that stays at the gate after an abort is therefore not re-admitted until `request` drops.
- IDLE:
  - `request && armed && space_avail` → RAISING, timer ← MOVE_CYCLES-1.
  - `deny` = `request && armed && !space_avail` (combinational from state/inputs).
- RAISING: `motor_up`=1. At timer==0 → OPEN, timer ← OPEN_CYCLES-1; else decrement.
- OPEN: `barrier_open`=1.
  - `pass_sensor`=1 → PASSING. This takes priority over expiry.
  - Otherwise timer==0 → LOWERING, timer ← MOVE_CYCLES-1, `timeout` pulses.
- PASSING: `barrier_open`=1, no timer. `pass_sensor`=0 → LOWERING, timer ← MOVE_CYCLES-1, `entry_pulse` pulses.
- LOWERING: `motor_down`=1.
  - `pass_sensor`=1 → safety reversal: RAISING, timer ← MOVE_CYCLES-1, no pulse. Sensor has priority over timer expiry.
  - Otherwise timer==0 → IDLE.
- After a safety reversal the sequence continues normally: RAISING → OPEN → PASSING.
- Exactly one `entry_pulse` per completed pass. A reversal after the pulse does not produce a second pulse unless the beam is cleared again from PASSING.
- `space_avail` is sampled only in IDLE; a change after admission is ignored.
- Timer width: `$clog2(max(MOVE_CYCLES, OPEN_CYCLES))`, minimum 1 bit. Unsigned down-counter, never wraps (reloaded before it reaches 0-1).
- `motor_up` and `motor_down` are never high in the same cycle.

## Timing
- Reset:
  - State ← IDLE, timer ← 0, `armed` ← 1.
  - All outputs 0 the cycle after reset is sampled.
  - Reset mid-motion drops the motor drive immediately at the next edge.
- Moore outputs `motor_up`, `motor_down`, `barrier_open` are decoded from registered state.
- `entry_pulse` and `timeout` are registered. Each is high for exactly the first cycle of LOWERING entered by the corresponding transition.
- Latency:
  - Admission at edge N → `motor_up` high cycles N+1 … N+MOVE_CYCLES.
  - `barrier_open` from N+MOVE_CYCLES+1.
  - Unattended open window is exactly OPEN_CYCLES cycles.
  - Beam clear sampled at edge M → `entry_pulse` high in cycle M+1, which is also the first `motor_down` cycle.
- `deny` has zero latency (combinational) in IDLE.

## Structure
- Shared `parking_pkg`:
  - `gate_state_t` enum (IDLE, RAISING, OPEN, PASSING, LOWERING).
  - Default constants `GATE_MOVE_CYCLES`=4 and `GATE_OPEN_CYCLES`=16.
  - Capacity constants shared with the space counters.
- Sub-modules: none; timer and FSM live in one module.
- Debounce of `request` and `pass_sensor` is done upstream by the existing debounce block, not here.

## Test plan
- Reset, then `request`=1, `space_avail`=1 → `motor_up` high 4 cycles, `barrier_open` from cycle 5. Pulse `pass_sensor` 3 cycles → one `entry_pulse`, `motor_down` 4 cycles, back to IDLE.
- `space_avail`=0, `request`=1 → `deny`=1, motors idle for 50 cycles. Raise `space_avail` → admission next edge, `deny` falls.
- Admit with no pass → `timeout` pulse after 16 open cycles, lowering, zero `entry_pulse`. `request` held high → no re-admission until `request` low one cycle.
- `pass_sensor` asserted in LOWERING cycle 2 → RAISING next edge, full re-open. Subsequent clear → total `entry_pulse` count = 1.
- Assert reset during RAISING cycle 2 → all outputs 0 next cycle; state IDLE, `armed`=1.
- `pass_sensor` rises on the same edge the open timer expires → PASSING taken, no `timeout`.

Source files
------------

// File: rtl/parking_pkg.sv
// parking_pkg: shared types and constants for the parking entry/exit subsystem.
// Rev 1.0
`default_nettype none

package parking_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAISING  = 3'd1,
    OPEN     = 3'd2,
    PASSING  = 3'd3,
    LOWERING = 3'd4
  } gate_state_t;

  localparam int GATE_MOVE_CYCLES = 4;
  localparam int GATE_OPEN_CYCLES = 16;

  // Lot capacity, shared with the space counters.
  localparam int LOT_CAPACITY = 64;
  localparam int LOT_COUNT_W  = $clog2(LOT_CAPACITY + 1);

  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: gate sensors/requests in, motor drive and counter pulses out.
// Rev 1.0
`default_nettype none

interface parking_gate_ctrl_if;
  logic request;
  logic space_avail;
  logic pass_sensor;
  logic motor_up;
  logic motor_down;
  logic barrier_open;
  logic deny;
  logic entry_pulse;
  logic timeout;

  modport master (
    input  request, space_avail, pass_sensor,
    output motor_up, motor_down, barrier_open, deny, entry_pulse, timeout
  );

  modport slave (
    output request, space_avail, pass_sensor,
    input  motor_up, motor_down, barrier_open, deny, entry_pulse, timeout
  );
endinterface

`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry barrier sequencer; pulses the space counter only after a confirmed pass.
// Rev 1.0
`default_nettype none

module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int MOVE_CYCLES = GATE_MOVE_CYCLES,
  parameter int OPEN_CYCLES = GATE_OPEN_CYCLES
) (
  input  wire logic          clk,
  input  wire logic          reset,
  parking_gate_ctrl_if.master gate
);

  localparam int TW = timer_width(MOVE_CYCLES, OPEN_CYCLES);
  localparam logic [TW-1:0] MOVE_RELOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_RELOAD = TW'(OPEN_CYCLES - 1);

  gate_state_t   state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          armed_q, armed_n;
  logic          entry_q, entry_n;
  logic          timeout_q, timeout_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      armed_q   <= 1'b1;
      entry_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      timer_q   <= timer_n;
      armed_q   <= armed_n;
      entry_q   <= entry_n;
      timeout_q <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    timer_n   = timer_q;
    armed_n   = armed_q;
    entry_n   = 1'b0;
    timeout_n = 1'b0;
    // A car still at the gate after an abort must back off before it is admitted again.
    if (!gate.request) armed_n = 1'b1;
    case (state_q)
      IDLE: begin
        if (gate.request && armed_q && gate.space_avail) begin
          state_n = RAISING;
          timer_n = MOVE_RELOAD;
          armed_n = 1'b0;
        end
      end
      RAISING: begin
        if (timer_q == '0) begin
          state_n = OPEN;
          timer_n = OPEN_RELOAD;
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end
      OPEN: begin
        if (gate.pass_sensor) begin
          state_n = PASSING;
        end else if (timer_q == '0) begin
          state_n   = LOWERING;
          timer_n   = MOVE_RELOAD;
          timeout_n = 1'b1;
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end
      PASSING: begin
        if (!gate.pass_sensor) begin
          state_n = LOWERING;
          timer_n = MOVE_RELOAD;
          entry_n = 1'b1;
        end
      end
      LOWERING: begin
        // Beam broken under a descending barrier: reverse before the timer can finish.
        if (gate.pass_sensor) begin
          state_n = RAISING;
          timer_n = MOVE_RELOAD;
          armed_n = 1'b0;
        end else if (timer_q == '0) begin
          state_n = IDLE;
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  assign gate.motor_up     = (state_q == RAISING);
  assign gate.motor_down   = (state_q == LOWERING);
  assign gate.barrier_open = (state_q == OPEN) || (state_q == PASSING);
  assign gate.deny         = (state_q == IDLE) && gate.request && armed_q && !gate.space_avail;
  assign gate.entry_pulse  = entry_q;
  assign gate.timeout      = timeout_q;

endmodule

`default_nettype wire
